// File: rtl/long_divider_pkg.sv
// Shared defaults and FSM encoding for the sequential restoring long divider.
package long_divider_pkg;

    localparam int DW_DEF = 7;
    localparam int MW_DEF = 4;
    localparam int QW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/long_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, compare with the
// divisor and conditionally subtract.
module long_divider_step
    import long_divider_pkg::*;
#(
    parameter int MW = MW_DEF
) (
    input  logic [MW:0]   partial,
    input  logic          dbit,
    input  logic [MW-1:0] divisor,
    output logic [MW:0]   partial_next,
    output logic          qbit
);

    logic [MW+1:0] shifted;
    logic [MW+1:0] divisor_ext;

    // One extra bit of headroom keeps the compare exact even when the divisor is zero.
    assign shifted     = {partial, dbit};
    assign divisor_ext = {2'b00, divisor};

    assign qbit         = (shifted >= divisor_ext);
    assign partial_next = (MW+1)'(qbit ? (shifted - divisor_ext) : shifted);

endmodule

// File: rtl/long_divider_seq.sv
// Sequential restoring long divider, one quotient bit per clock, MSB first.
// Optional LONG_DIVIDER_ZERO_SKIP_EN: a zero divisor bypasses the iterations.
module long_divider_seq
    import long_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF,
    parameter int QW = QW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] D,
    input  logic [MW-1:0] M,
    output logic [QW-1:0] Q,
    output logic [MW-1:0] R,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          dbz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] dividend;
    logic [MW-1:0] divisor;
    logic [MW:0]   partial;
    logic [DW-1:0] quot;
    logic [CW-1:0] cnt;
    logic [MW:0]   partial_step;
    logic          qbit;
    logic          skip_zero;
    logic          finish;
    logic          div_zero;

`ifdef LONG_DIVIDER_ZERO_SKIP_EN
    assign skip_zero = (M == '0);
`else
    assign skip_zero = 1'b0;
`endif

    long_divider_step #(
        .MW(MW)
    ) u_step (
        .partial      (partial),
        .dbit         (dividend[cnt]),
        .divisor      (divisor),
        .partial_next (partial_step),
        .qbit         (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = skip_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The zero-skip path enters DONE with cnt=1 to keep its two-cycle latency.
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign div_zero = (divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend <= '0;
            divisor  <= '0;
            partial  <= '0;
            quot     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend <= D;
                        divisor  <= M;
                        if (skip_zero) begin
                            partial <= {1'b0, D[MW-1:0]};
                            quot    <= '1;
                            cnt     <= CW'(1);
                        end else begin
                            partial <= '0;
                            quot    <= '0;
                            cnt     <= CW'(DW - 1);
                        end
                    end
                end
                RUN: begin
                    partial <= partial_step;
                    quot    <= {quot[DW-2:0], qbit};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Result registers hold until the next completed division or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= '0;
            R    <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                Q   <= quot[QW-1:0];
                R   <= partial[MW-1:0];
                dbz <= div_zero;
                ovf <= !div_zero && (|quot[DW-1:QW]);
            end
        end
    end

endmodule

// File: tb/tb_long_divider_seq.sv
// Directed scoreboard bench for long_divider_seq.
module tb_long_divider_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] D;
    logic [3:0] M;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       dbz;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dbz;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef LONG_DIVIDER_ZERO_SKIP_EN
    localparam int ZLAT  = 2;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 8;
    localparam int ZBUSY = 7;
`endif

    long_divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .D     (D),
        .M     (M),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [6:0] d, input logic [3:0] m);
        res_t       e;
        logic [6:0] qf;
        if (m == 4'd0) begin
            qf  = 7'h7F;
            e.r = d[3:0];
        end else begin
            qf  = d / {3'b000, m};
            e.r = 4'(d % {3'b000, m});
        end
        e.q   = qf[3:0];
        e.ovf = (m != 4'd0) && (qf > 7'd15);
        e.dbz = (m == 4'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_Q"},   32'(Q),   32'(e.q));
            check({tag, "_R"},   32'(R),   32'(e.r));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            check({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
        end
    endtask

    // Drives start across one edge; returns just after the accepting edge.
    task automatic launch(input logic [6:0] d, input logic [3:0] m);
        D     = d;
        M     = m;
        start = 1'b1;
        sb.push_back(model(d, m));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [6:0] d, input logic [3:0] m,
                          input int exp_lat, input int exp_busy, input bit glitch);
        int cyc;
        int bcnt;
        bit seen;
        launch(d, m);
        cyc  = 0;
        bcnt = busy ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (glitch && cyc == 3) begin
                D     = 7'd3;
                M     = 4'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
            check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
            check_result(tag);
            @(posedge clk);
            #1;
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int pulses;
        int first_edge;
        int n;

        rst_n = 1'b0;
        start = 1'b0;
        D     = '0;
        M     = '0;
        #12;
        check("reset_Q",    32'(Q),    32'd0);
        check("reset_R",    32'(R),    32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        check("reset_dbz",  32'(dbz),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("d7m2",    7'd7,   4'd2,  8, 7, 1'b0);
        run_op("d6m2",    7'd6,   4'd2,  8, 7, 1'b0);
        run_op("d9m4",    7'd9,   4'd4,  8, 7, 1'b0);
        run_op("d12m5",   7'd12,  4'd5,  8, 7, 1'b0);
        run_op("d100m3",  7'd100, 4'd3,  8, 7, 1'b0);
        run_op("d127m15", 7'd127, 4'd15, 8, 7, 1'b0);
        run_op("d5m0",    7'd5,   4'd0,  ZLAT, ZBUSY, 1'b0);
        run_op("ignore",  7'd9,   4'd4,  8, 7, 1'b1);

        // Abort mid-run with an asynchronous reset.
        launch(7'd100, 4'd3);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_Q",    32'(Q),    32'd0);
        check("abort_R",    32'(R),    32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        check("abort_dbz",  32'(dbz),  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_idle",    32'(busy),   32'd0);

        // Back-to-back: start held high through the first done.
        D     = 7'd7;
        M     = 4'd2;
        start = 1'b1;
        sb.push_back(model(7'd7, 4'd2));
        @(posedge clk);
        #1;
        pulses     = 0;
        first_edge = 0;
        n          = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (pulses == 1 && n == first_edge + 1) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_edge = n;
                    check("b2b_first_latency", 32'(n), 32'd8);
                    check_result("b2b_first");
                    D = 7'd12;
                    M = 4'd5;
                    sb.push_back(model(7'd12, 4'd5));
                end else begin
                    check("b2b_second_gap", 32'(n - first_edge), 32'd9);
                    check_result("b2b_second");
                    break;
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("b2b_pulses",  32'(pulses),    32'd2);
        check("sb_drained",  32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
